// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_unit_if                                                   |
// | Brief    : Fetch front-end bundle: branch redirect, imem request/response  |
// |            and decode-side instruction handshake.                          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface fetch_unit_if;
   logic        PCsrc;
   logic [31:0] BranchPC;
   logic [31:0] ImmOp;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;

   // master is the fetch unit's view; slave is memory plus decode
   modport master (
      input  PCsrc, BranchPC, ImmOp,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  instr_ready,
      output imem_req_valid, imem_req_addr,
      output instr_valid, instr, instr_pc
   );

   modport slave (
      output PCsrc, BranchPC, ImmOp,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output instr_ready,
      input  imem_req_valid, imem_req_addr,
      input  instr_valid, instr, instr_pc
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_unit                                                      |
// | Brief    : Credit-limited instruction fetch with in-order pending-PC queue,|
// |            registered instruction buffer and branch flush with drop count. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  wire logic    clk,
   input  wire logic    rst,
   fetch_unit_if.master bus
);
   localparam int                c_PW      = $clog2(DEPTH);
   localparam int                c_CW      = c_PW + 1;
   localparam logic [c_CW-1:0]   c_DEPTH_C = c_CW'(DEPTH);
   localparam logic [c_CW:0]     c_DEPTH_X = (c_CW + 1)'(DEPTH);
   localparam logic [c_PW-1:0]   c_PONE    = c_PW'(1);
   localparam logic [c_CW-1:0]   c_CONE    = c_CW'(1);

   logic [31:0]     r_pc;
   logic [c_CW-1:0] r_count;
   logic [c_CW-1:0] r_outstanding;
   logic [c_CW-1:0] r_drop;
   logic [c_PW-1:0] r_head;
   logic [c_PW-1:0] r_tail;
   logic [c_PW-1:0] r_pq_head;
   logic [c_PW-1:0] r_pq_tail;
   logic [31:0]     r_buf_instr [DEPTH];
   logic [31:0]     r_buf_pc    [DEPTH];
   logic [31:0]     r_pq        [DEPTH];

   logic            w_valid;
   logic            w_req_valid;
   logic            w_accept;
   logic            w_rsp;
   logic            w_drop_rsp;
   logic            w_push;
   logic            w_pop;
   logic [c_CW:0]   w_credit_used;
   logic [c_CW-1:0] w_outstanding_nxt;

   assign w_valid           = (r_count != '0);
   assign w_credit_used     = {1'b0, r_count} + {1'b0, r_outstanding};
   assign w_req_valid       = !rst && !bus.PCsrc && (w_credit_used < c_DEPTH_X);
   assign w_accept          = w_req_valid && bus.imem_req_ready;
   // Responses with nothing in flight are stray (e.g. from before a reset)
   assign w_rsp             = bus.imem_rsp_valid && (r_outstanding != '0);
   assign w_drop_rsp        = w_rsp && (r_drop != '0);
   assign w_push            = w_rsp && (r_drop == '0);
   assign w_pop             = w_valid && bus.instr_ready;
   assign w_outstanding_nxt = r_outstanding + c_CW'(w_accept) - c_CW'(w_rsp);

   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_req_addr  = r_pc;
   assign bus.instr_valid    = w_valid;
   assign bus.instr          = w_valid ? r_buf_instr[r_head] : 32'd0;
   assign bus.instr_pc       = w_valid ? r_buf_pc[r_head]    : 32'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc          <= RESET_PC;
         r_count       <= '0;
         r_outstanding <= '0;
         r_drop        <= '0;
         r_head        <= '0;
         r_tail        <= '0;
         r_pq_head     <= '0;
         r_pq_tail     <= '0;
      end else begin
         r_outstanding <= w_outstanding_nxt;
         if (bus.PCsrc) begin
            // No accept can occur here, so every remaining in-flight word is stale
            r_pc      <= bus.BranchPC + bus.ImmOp;
            r_drop    <= w_outstanding_nxt;
            r_count   <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_pq_head <= '0;
            r_pq_tail <= '0;
         end else begin
            if (w_accept) begin
               r_pc      <= r_pc + 32'd4;
               r_pq_tail <= r_pq_tail + c_PONE;
            end
            if (w_push) begin
               r_tail    <= r_tail + c_PONE;
               r_pq_head <= r_pq_head + c_PONE;
            end
            if (w_pop) begin
               r_head <= r_head + c_PONE;
            end
            if (w_drop_rsp) begin
               r_drop <= r_drop - c_CONE;
            end
            r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_pq[r_pq_tail] <= r_pc;
      end
      if (w_push) begin
         r_buf_instr[r_tail] <= bus.imem_rsp_data;
         r_buf_pc[r_tail]    <= r_pq[r_pq_head];
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_push && !bus.PCsrc && !w_pop && (r_count == c_DEPTH_C)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch_unit                                                   |
// | Brief    : Directed scoreboard bench for fetch_unit with a latency model.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mem_req_t;

   mem_req_t    mem_q[$];
   logic [31:0] exp_addr_q[$];
   logic [63:0] exp_instr_q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc      = 0;
   int          mem_lat  = 1;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 + {22'd0, a[11:2]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Memory: fixed latency, in order; also scoreboards accepted addresses
   initial begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'd0;
      forever begin
         @(negedge clk);
         cyc++;
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data  = 32'd0;
         if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
         end
         #3;
         if (bus.imem_req_valid && bus.imem_req_ready) begin
            mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + mem_lat});
            if (exp_addr_q.size() > 0)
               check("req_addr", 64'(bus.imem_req_addr), 64'(exp_addr_q.pop_front()));
         end
      end
   end

   // Instruction monitor
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (bus.instr_valid && bus.instr_ready && exp_instr_q.size() > 0)
            check("instr", {bus.instr_pc, bus.instr}, exp_instr_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int lat);
      @(negedge clk);
      rst       = 1'b1;
      bus.PCsrc = 1'b0;
      step(3);
      exp_addr_q.delete();
      exp_instr_q.delete();
      mem_lat = lat;
   endtask

   task automatic exp_instr(input logic [31:0] pc);
      exp_instr_q.push_back({pc, mem_word(pc)});
   endtask

   task automatic wait_drain(input string name);
      int k = 0;
      while ((exp_instr_q.size() > 0 || exp_addr_q.size() > 0) && k < 40) begin
         step();
         k++;
      end
      check({name, "_drained"}, 64'(exp_instr_q.size() + exp_addr_q.size()), 64'd0);
   endtask

   initial begin
      rst                = 1'b1;
      bus.PCsrc          = 1'b0;
      bus.BranchPC       = 32'd0;
      bus.ImmOp          = 32'd0;
      bus.imem_req_ready = 1'b0;
      bus.instr_ready    = 1'b0;

      // Streaming fetch, 1-cycle memory
      do_reset(1);
      bus.imem_req_ready = 1'b1;
      bus.instr_ready    = 1'b1;
      #2;
      check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
      check("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
      check("rst_instr", {bus.instr_pc, bus.instr}, 64'd0);
      step();
      exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
      exp_instr(32'h0); exp_instr(32'h4); exp_instr(32'h8); exp_instr(32'hC);
      rst = 1'b0;
      #2;
      check("t1_first_req", {31'd0, bus.imem_req_valid, bus.imem_req_addr}, {32'd1, 32'h0});
      step(); #2;
      check("t1_no_early_valid", 64'(bus.instr_valid), 64'd0);
      step(); #2;
      check("t1_first_valid", 64'(bus.instr_valid), 64'd1);
      wait_drain("t1");

      // Decode stalled: credit limit of two requests
      do_reset(1);
      bus.instr_ready = 1'b0;
      exp_addr_q = '{32'h0, 32'h4, 32'h8};
      exp_instr(32'h0); exp_instr(32'h4); exp_instr(32'h8);
      rst = 1'b0;
      step(2);
      for (int i = 0; i < 3; i++) begin
         #2;
         check("t2_req_blocked", 64'(bus.imem_req_valid), 64'd0);
         check("t2_head_stable", {bus.instr_pc, bus.instr}, {32'h0, mem_word(32'h0)});
         step();
      end
      bus.instr_ready = 1'b1;
      wait_drain("t2");

      // Memory not ready for three cycles
      do_reset(1);
      bus.imem_req_ready = 1'b0;
      exp_addr_q = '{32'h0, 32'h4};
      exp_instr(32'h0); exp_instr(32'h4);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #2;
         check("t3_req_held", {31'd0, bus.imem_req_valid, bus.imem_req_addr}, {32'd1, 32'h0});
         step();
      end
      bus.imem_req_ready = 1'b1;
      wait_drain("t3");

      // Redirect with two requests in flight, 2-cycle memory
      do_reset(2);
      exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
      exp_instr(32'h8); exp_instr(32'hC);
      rst = 1'b0;
      step(2);
      bus.BranchPC = 32'h10;
      bus.ImmOp    = 32'hFFFF_FFF8;
      bus.PCsrc    = 1'b1;
      #2;
      check("t4_req_suppressed", 64'(bus.imem_req_valid), 64'd0);
      step();
      bus.PCsrc = 1'b0;
      #2;
      check("t4_target_req", {31'd0, bus.imem_req_valid, bus.imem_req_addr}, {32'd1, 32'h8});
      check("t4_no_stale_0", 64'(bus.instr_valid), 64'd0);
      step(); #2;
      check("t4_no_stale_1", 64'(bus.instr_valid), 64'd0);
      step(); #2;
      check("t4_no_stale_2", 64'(bus.instr_valid), 64'd0);
      step(); #2;
      check("t4_target_valid", {31'd0, bus.instr_valid, bus.instr_pc}, {32'd1, 32'h8});
      wait_drain("t4");

      // Redirect coinciding with a pop and a response
      do_reset(1);
      exp_addr_q = '{32'h0, 32'h4, 32'h120, 32'h124};
      exp_instr(32'h0); exp_instr(32'h120); exp_instr(32'h124);
      rst = 1'b0;
      step(2);
      bus.BranchPC = 32'h100;
      bus.ImmOp    = 32'h20;
      bus.PCsrc    = 1'b1;
      #2;
      check("t5_head_valid", 64'(bus.instr_valid), 64'd1);
      step();
      bus.PCsrc = 1'b0;
      #2;
      check("t5_flushed", 64'(bus.instr_valid), 64'd0);
      check("t5_target_req", {31'd0, bus.imem_req_valid, bus.imem_req_addr}, {32'd1, 32'h120});
      step(); #2;
      check("t5_wait", 64'(bus.instr_valid), 64'd0);
      step(); #2;
      check("t5_target_valid", {31'd0, bus.instr_valid, bus.instr_pc}, {32'd1, 32'h120});
      wait_drain("t5");

      // Reset pulse mid-stream with a response still in flight
      do_reset(2);
      exp_addr_q = '{32'h0, 32'h4, 32'h0, 32'h4};
      exp_instr(32'h0); exp_instr(32'h4);
      rst = 1'b0;
      step(2);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #2;
      check("t6_instr_valid", 64'(bus.instr_valid), 64'd0);
      check("t6_instr", {bus.instr_pc, bus.instr}, 64'd0);
      check("t6_first_req", {31'd0, bus.imem_req_valid, bus.imem_req_addr}, {32'd1, 32'h0});
      step(); #2;
      check("t6_leftover_ignored", 64'(bus.instr_valid), 64'd0);
      step(); #2;
      check("t6_wait", 64'(bus.instr_valid), 64'd0);
      step(); #2;
      check("t6_first_valid", {31'd0, bus.instr_valid, bus.instr_pc}, {32'd1, 32'h0});
      wait_drain("t6");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
